// File: rtl/slot_irq_ctrl_pkg.sv
// Shared constants, scheduler state encoding and summary-word packing for slot_irq_ctrl.
// Latency: none (declarations only).
// Backpressure: not applicable.
package slot_irq_ctrl_pkg;

    localparam int ADDR_MASK_BASE = 32;
    localparam int ADDR_CLR_BASE  = 40;
    localparam int ADDR_SUMMARY   = 48;
    localparam int MAX_SLOTS      = 8;

    // Summary word layout: {irq_valid, 4'b0, irq_slot[2:0], slot_vec[7:0]}
    localparam int SUM_W         = 16;
    localparam int SUM_VALID_BIT = 15;
    localparam int SUM_SLOT_LSB  = 8;
    localparam int SUM_VEC_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_t;

    function automatic logic [SUM_W-1:0] pack_summary(input logic valid,
                                                      input logic [2:0] slot,
                                                      input logic [MAX_SLOTS-1:0] vec);
        logic [SUM_W-1:0] w;
        w = '0;
        w[SUM_VALID_BIT]                 = valid;
        w[SUM_SLOT_LSB +: 3]             = slot;
        w[SUM_VEC_LSB +: MAX_SLOTS]      = vec;
        return w;
    endfunction

endpackage

// File: rtl/slot_irq_ctrl_edge_latch.sv
// One slot: synchronise raw pins, detect rising edges, hold them in pending bits with write-1-to-clear.
// Latency: SYNC_STAGES+1 cycles from pin rise to pending set.
// Backpressure: none; clears are applied the cycle they are presented, a new edge beats a clear.
module slot_edge_latch
    import slot_irq_ctrl_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              armed,
    input  logic [DATA_W-1:0] pin,
    input  logic [DATA_W-1:0] clr_mask,
    output logic [DATA_W-1:0] pending
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q;
    logic [DATA_W-1:0]                  prev_q;
    logic [DATA_W-1:0]                  synced;
    logic [DATA_W-1:0]                  rise;

    assign synced = sync_q[SYNC_STAGES-1];
    // Edges are ignored until the chain has flushed after reset, so pins already high stay quiet.
    assign rise   = synced & ~prev_q & {DATA_W{armed}};

    // Synchroniser shift, previous-value capture and pending update (set has priority over clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pending <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q  <= synced;
            pending <= (pending & ~clr_mask) | rise;
        end
    end

endmodule

// File: rtl/slot_irq_ctrl.sv
// Per-slot interrupt controller: edge-latched pending bits, mask gating, irq and a round-robin slot presenter.
// Latency: rdata 1 cycle after bus_re; irq 1 cycle after slot_vec; irq_valid within N_SLOTS+1 cycles.
// Backpressure: none; bus strobes are single-cycle and always accepted.
module slot_irq_ctrl
    import slot_irq_ctrl_pkg::*;
#(
    parameter int N_SLOTS     = 8,
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [N_SLOTS*DATA_W-1:0] slot_in,
    input  logic                      bus_we,
    input  logic                      bus_re,
    input  logic [ADDR_W-1:0]         bus_addr,
    input  logic [DATA_W-1:0]         bus_wdata,
    output logic [DATA_W-1:0]         bus_rdata,
    output logic                      irq,
    output logic [2:0]                irq_slot,
    output logic                      irq_valid
);

    localparam int ARM_CYC = SYNC_STAGES + 1;
    localparam int ARM_W   = $clog2(SYNC_STAGES + 2);

    logic [ARM_W-1:0]     arm_cnt;
    logic                 armed;
    logic [DATA_W-1:0]    mask_q   [N_SLOTS];
    logic [DATA_W-1:0]    pending  [N_SLOTS];
    logic [DATA_W-1:0]    clr_mask [N_SLOTS];
    logic [N_SLOTS-1:0]   mask_we;
    logic [MAX_SLOTS-1:0] slot_vec;
    logic [DATA_W-1:0]    rd_mux;

    sched_state_t state_q, state_d;
    logic [2:0]   ptr_q, ptr_d;
    logic [3:0]   lap_q, lap_d;
    logic [2:0]   last_q, last_d;
    logic [2:0]   slot_d;
    logic         valid_d;

    function automatic logic [2:0] next_slot(input logic [2:0] p);
        return (p == 3'(N_SLOTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Count cycles after reset release until the synchronisers hold real pin values.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)     arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
    assign armed = (arm_cnt == ARM_W'(ARM_CYC));

    // Address decode for mask writes and W1C strobes.
    always_comb begin
        for (int s = 0; s < N_SLOTS; s++) begin
            mask_we[s]  = bus_we && (bus_addr == ADDR_W'(ADDR_MASK_BASE + s));
            clr_mask[s] = (bus_we && (bus_addr == ADDR_W'(ADDR_CLR_BASE + s))) ? bus_wdata : '0;
        end
    end

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        slot_edge_latch #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_latch (
            .clk      (sys_clk),
            .rst      (sys_rst),
            .armed    (armed),
            .pin      (slot_in[g*DATA_W +: DATA_W]),
            .clr_mask (clr_mask[g]),
            .pending  (pending[g])
        );
    end

    // Mask registers.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int s = 0; s < N_SLOTS; s++) mask_q[s] <= '0;
        end else begin
            for (int s = 0; s < N_SLOTS; s++) if (mask_we[s]) mask_q[s] <= bus_wdata;
        end
    end

    // Per-slot serviceable flag; slots beyond N_SLOTS are tied off.
    always_comb begin
        slot_vec = '0;
        for (int s = 0; s < N_SLOTS; s++) slot_vec[s] = |(pending[s] & mask_q[s]);
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rd_mux = '0;
        for (int s = 0; s < N_SLOTS; s++) begin
            if (bus_addr == ADDR_W'(ADDR_MASK_BASE + s)) rd_mux = mask_q[s];
            if (bus_addr == ADDR_W'(ADDR_CLR_BASE + s))  rd_mux = pending[s];
        end
        if (bus_addr == ADDR_W'(ADDR_SUMMARY))
            rd_mux = DATA_W'(pack_summary(irq_valid, irq_slot, slot_vec));
    end

    // Registered read data and irq; rdata holds until the next read strobe.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus_rdata <= '0;
            irq       <= 1'b0;
        end else begin
            if (bus_re) bus_rdata <= rd_mux;
            irq <= |slot_vec;
        end
    end

    // Scheduler state register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            lap_q     <= '0;
            last_q    <= '0;
            irq_slot  <= '0;
            irq_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            lap_q     <= lap_d;
            last_q    <= last_d;
            irq_slot  <= slot_d;
            irq_valid <= valid_d;
        end
    end

    // Round-robin scan starting after the last serviced slot; one slot tested per cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lap_d   = lap_q;
        last_d  = last_q;
        slot_d  = irq_slot;
        valid_d = irq_valid;
        case (state_q)
            ST_IDLE: begin
                if (|slot_vec) begin
                    state_d = ST_SCAN;
                    ptr_d   = next_slot(last_q);
                    lap_d   = '0;
                end
            end
            ST_SCAN: begin
                if (slot_vec[ptr_q]) begin
                    slot_d  = ptr_q;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (lap_q == 4'(N_SLOTS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = next_slot(ptr_q);
                    lap_d = lap_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!slot_vec[irq_slot]) begin
                    valid_d = 1'b0;
                    last_d  = irq_slot;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_slot_irq_ctrl.sv
// Self-checking bench for slot_irq_ctrl: register reads go through an expected-value queue.
// Latency: reads are compared 1 cycle after the read strobe.
// Backpressure: none.
module tb_slot_irq_ctrl;

    localparam int N_SLOTS     = 8;
    localparam int DATA_W      = 16;
    localparam int ADDR_W      = 6;
    localparam int SYNC_STAGES = 2;

    logic                      sys_clk = 1'b0;
    logic                      sys_rst = 1'b1;
    logic [N_SLOTS*DATA_W-1:0] slot_in;
    logic                      bus_we;
    logic                      bus_re;
    logic [ADDR_W-1:0]         bus_addr;
    logic [DATA_W-1:0]         bus_wdata;
    logic [DATA_W-1:0]         bus_rdata;
    logic                      irq;
    logic [2:0]                irq_slot;
    logic                      irq_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    string             tag_q[$];

    slot_irq_ctrl #(
        .N_SLOTS     (N_SLOTS),
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .slot_in   (slot_in),
        .bus_we    (bus_we),
        .bus_re    (bus_re),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq),
        .irq_slot  (irq_slot),
        .irq_valid (irq_valid)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read-data monitor: each read strobe retires one queued expectation.
    initial begin
        forever begin
            @(posedge sys_clk);
            if (bus_re) begin
                #1;
                if (exp_q.size() == 0)
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                else
                    check(tag_q.pop_front(), 32'(bus_rdata), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic bus_write(input int addr, input logic [DATA_W-1:0] data);
        bus_addr  = ADDR_W'(addr);
        bus_wdata = data;
        bus_we    = 1'b1;
        tick(1);
        bus_we    = 1'b0;
    endtask

    task automatic bus_read(input int addr, input logic [DATA_W-1:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_addr = ADDR_W'(addr);
        bus_re   = 1'b1;
        tick(1);
        bus_re   = 1'b0;
    endtask

    task automatic bus_rw(input int addr, input logic [DATA_W-1:0] data,
                          input logic [DATA_W-1:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        bus_addr  = ADDR_W'(addr);
        bus_wdata = data;
        bus_we    = 1'b1;
        bus_re    = 1'b1;
        tick(1);
        bus_we    = 1'b0;
        bus_re    = 1'b0;
    endtask

    task automatic set_pin(input int s, input int b, input logic v);
        slot_in[s*DATA_W + b] = v;
    endtask

    // Wait up to budget cycles for irq (or irq_valid) to reach val, then record the outcome.
    task automatic wait_sig(input string tag, input bit use_valid, input logic val, input int budget);
        int   i;
        logic cur;
        i   = 0;
        cur = use_valid ? irq_valid : irq;
        while (cur !== val && i < budget) begin
            tick(1);
            i++;
            cur = use_valid ? irq_valid : irq;
        end
        check(tag, 32'(cur), 32'(val));
    endtask

    task automatic apply_reset();
        sys_rst = 1'b1;
        tick(2);
        sys_rst = 1'b0;
        tick(SYNC_STAGES + 3);
    endtask

    initial begin
        slot_in   = '1;
        bus_we    = 1'b0;
        bus_re    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        tick(3);
        check("rst_irq",       32'(irq),       32'd0);
        check("rst_irq_valid", 32'(irq_valid), 32'd0);
        check("rst_irq_slot",  32'(irq_slot),  32'd0);
        check("rst_rdata",     32'(bus_rdata), 32'd0);

        // 1: pins high through reset must not create edges
        sys_rst = 1'b0;
        tick(1);
        for (int s = 0; s < N_SLOTS; s++) bus_write(32 + s, 16'hffff);
        tick(10);
        check("t1_irq", 32'(irq), 32'd0);
        for (int s = 0; s < N_SLOTS; s++) bus_read(40 + s, 16'h0000, "t1_pend");
        bus_read(48, 16'h0000, "t1_sum");

        slot_in = '0;
        apply_reset();

        // 2: single enabled edge on slot 0
        bus_write(32, 16'hffff);
        set_pin(0, 0, 1'b1);
        wait_sig("t2_irq_rise", 1'b0, 1'b1, SYNC_STAGES + 2);
        bus_read(40, 16'h0001, "t2_pend");
        wait_sig("t2_valid", 1'b1, 1'b1, N_SLOTS + 2);
        bus_read(48, 16'h8001, "t2_sum");
        bus_write(40, 16'h0001);
        wait_sig("t2_irq_fall", 1'b0, 1'b0, 2);
        wait_sig("t2_valid_fall", 1'b1, 1'b0, 2);

        // 3: masked edge latches but stays silent until unmasked
        set_pin(3, 5, 1'b1);
        tick(6);
        bus_read(43, 16'h0020, "t3_pend");
        check("t3_irq_masked", 32'(irq), 32'd0);
        bus_write(35, 16'h0020);
        wait_sig("t3_irq", 1'b0, 1'b1, 2);
        wait_sig("t3_valid", 1'b1, 1'b1, N_SLOTS + 2);
        check("t3_slot", 32'(irq_slot), 32'd3);
        bus_write(43, 16'h0020);
        wait_sig("t3_valid_fall", 1'b1, 1'b0, 3);

        // 4: round-robin ordering between slots 1 and 5
        apply_reset();
        bus_write(33, 16'hffff);
        bus_write(37, 16'hffff);
        set_pin(1, 0, 1'b1);
        set_pin(5, 0, 1'b1);
        wait_sig("t4_valid_a", 1'b1, 1'b1, SYNC_STAGES + N_SLOTS + 4);
        check("t4_slot_a", 32'(irq_slot), 32'd1);
        bus_write(41, 16'h0001);
        wait_sig("t4_drop_a", 1'b1, 1'b0, 3);
        wait_sig("t4_valid_b", 1'b1, 1'b1, N_SLOTS + 3);
        check("t4_slot_b", 32'(irq_slot), 32'd5);
        bus_write(45, 16'h0001);
        wait_sig("t4_drop_b", 1'b1, 1'b0, 3);
        set_pin(1, 0, 1'b0);
        set_pin(5, 0, 1'b0);
        tick(4);
        set_pin(1, 0, 1'b1);
        set_pin(5, 0, 1'b1);
        wait_sig("t4_valid_c", 1'b1, 1'b1, SYNC_STAGES + N_SLOTS + 4);
        check("t4_slot_c", 32'(irq_slot), 32'd1);
        bus_write(41, 16'h0001);
        bus_write(45, 16'h0001);

        // 5: new edge and W1C in the same cycle -> set wins
        set_pin(2, 7, 1'b1);
        tick(4);
        bus_read(42, 16'h0080, "t5_first");
        set_pin(2, 7, 1'b0);
        tick(4);
        set_pin(2, 7, 1'b1);
        tick(2);
        bus_write(42, 16'h0080);
        tick(1);
        bus_read(42, 16'h0080, "t5_set_wins");
        bus_write(42, 16'h0080);
        bus_read(42, 16'h0000, "t5_w1c");

        // Same-cycle read/write returns the old value; unmapped space reads zero
        bus_rw(38, 16'h1234, 16'h0000, "rw_prewrite");
        bus_read(38, 16'h1234, "rw_post");
        bus_write(10, 16'hbeef);
        bus_read(10, 16'h0000, "unmapped");

        // 6: asynchronous reset while holding a slot
        bus_write(36, 16'hffff);
        set_pin(4, 3, 1'b1);
        wait_sig("t6_valid", 1'b1, 1'b1, SYNC_STAGES + N_SLOTS + 4);
        check("t6_slot", 32'(irq_slot), 32'd4);
        bus_read(36, 16'hffff, "t6_mask");
        #3;
        sys_rst = 1'b1;
        #1;
        check("t6_rst_irq",   32'(irq),       32'd0);
        check("t6_rst_valid", 32'(irq_valid), 32'd0);
        check("t6_rst_slot",  32'(irq_slot),  32'd0);
        check("t6_rst_rdata", 32'(bus_rdata), 32'd0);
        tick(2);
        sys_rst = 1'b0;
        tick(10);
        check("t6_post_irq",   32'(irq),       32'd0);
        check("t6_post_valid", 32'(irq_valid), 32'd0);
        bus_read(44, 16'h0000, "t6_pend");
        bus_read(48, 16'h0000, "t6_sum");

        tick(2);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
